// File: rtl/alarm_pkg.sv
// Shared encodings, time limits and wrapped time arithmetic for the multi-alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'b000,
    SHOW_ALARM = 3'b001,
    EDIT_HR    = 3'b010,
    ALARM_SET  = 3'b011,
    EDIT_MIN   = 3'b100
  } ui_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'b00,
    R_RING   = 2'b01,
    R_SNOOZE = 2'b10
  } ring_state_t;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
  } hm_t;

  localparam logic [7:0] HR_MAX  = 8'd23;
  localparam logic [7:0] MIN_MAX = 8'd59;

  // delta is at most 59, so a single carry into the hour is enough
  function automatic hm_t time_add(input logic [7:0] h, input logic [7:0] m, input logic [7:0] d);
    hm_t        r;
    logic [7:0] s;
    s = m + d;
    if (s > MIN_MAX) begin
      r.min = s - (MIN_MAX + 8'd1);
      r.hr  = (h >= HR_MAX) ? 8'd0 : h + 8'd1;
    end else begin
      r.min = s;
      r.hr  = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_match.sv
// Combinational comparison of every enabled alarm against the current time; reports the lowest hit.
module alarm_match #(
  parameter int N_ALARMS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [N_ALARMS*8-1:0] al_hr_v,
  input  logic [N_ALARMS*8-1:0] al_min_v,
  input  logic [N_ALARMS-1:0]   al_en_v,
  input  logic [7:0]            hr,
  input  logic [7:0]            min,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  logic [N_ALARMS-1:0] match_s;

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_cmp
    assign match_s[g] = al_en_v[g] && (al_hr_v[g*8 +: 8] == hr) && (al_min_v[g*8 +: 8] == min);
  end

  assign hit = |match_s;

  // Scan from the top down so the lowest matching index is the one left standing
  always_comb begin
    idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      idx = match_s[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/alarm_ctrl_multi.sv
// Multi-alarm controller: UI FSM for viewing/editing alarms and an independent ring FSM
// with snooze, snooze limit and auto-off.
module alarm_ctrl_multi #(
  parameter int N_ALARMS   = 4,
  parameter int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 3,
  parameter int MAX_SNOOZE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       hr,
  input  logic [7:0]       min,
  input  logic             al,
  input  logic             sel_next,
  input  logic             set_al_hr,
  input  logic             set_al_min,
  input  logic             inc,
  input  logic             en_toggle,
  input  logic             snooze,
  input  logic             stop,
  output logic [IDX_W-1:0] al_sel,
  output logic [7:0]       al_hr,
  output logic [7:0]       al_min,
  output logic             al_en,
  output logic [2:0]       ui_state,
  output logic             buzzer,
  output logic [IDX_W-1:0] ring_id,
  output logic             snoozed
);
  import alarm_pkg::*;

  logic [N_ALARMS-1:0][7:0] alhr_r;
  logic [N_ALARMS-1:0][7:0] almin_r;
  logic [N_ALARMS-1:0]      alen_r;
  logic [IDX_W-1:0]         sel_r;
  ui_state_t                ui_r;
  ring_state_t              ring_r;
  logic                     buzzer_r;
  logic                     snoozed_r;
  logic [IDX_W-1:0]         ring_id_r;
  logic [7:0]               snz_cnt_r;
  logic [7:0]               ring_cnt_r;
  logic [7:0]               min_q_r;
  hm_t                      wake_r;
  logic                     tick_s;
  logic                     hit_s;
  logic [IDX_W-1:0]         hit_idx_s;
  hm_t                      snooze_wake_s;

  assign al_sel        = sel_r;
  assign al_hr         = alhr_r[sel_r];
  assign al_min        = almin_r[sel_r];
  assign al_en         = alen_r[sel_r];
  assign ui_state      = ui_r;
  assign buzzer        = buzzer_r;
  assign ring_id       = ring_id_r;
  assign snoozed       = snoozed_r;
  assign tick_s        = (min != min_q_r);
  assign snooze_wake_s = time_add(hr, min, 8'(SNOOZE_MIN));

  alarm_match #(.N_ALARMS(N_ALARMS), .IDX_W(IDX_W)) u_match (
    .al_hr_v (alhr_r),
    .al_min_v(almin_r),
    .al_en_v (alen_r),
    .hr      (hr),
    .min     (min),
    .hit     (hit_s),
    .idx     (hit_idx_s)
  );

  // Previous-minute register for edge detection
  always_ff @(posedge clk) begin
    min_q_r <= min;
  end

  // UI FSM: selection, field editing and enable handling
  always_ff @(posedge clk) begin
    if (rst) begin
      alhr_r  <= '0;
      almin_r <= '0;
      alen_r  <= '0;
      sel_r   <= '0;
      ui_r    <= SHOW_TIME;
    end else begin
      case (ui_r)
        SHOW_TIME: begin
          if (al) ui_r <= SHOW_ALARM;
        end
        SHOW_ALARM: begin
          if (sel_next) sel_r <= (sel_r == IDX_W'(N_ALARMS - 1)) ? '0 : sel_r + IDX_W'(1);
          if (en_toggle) alen_r[sel_r] <= ~alen_r[sel_r];
          if (!al)             ui_r <= SHOW_TIME;
          else if (set_al_hr)  ui_r <= EDIT_HR;
          else if (set_al_min) ui_r <= EDIT_MIN;
        end
        EDIT_HR: begin
          if (inc) alhr_r[sel_r] <= (alhr_r[sel_r] >= HR_MAX) ? 8'd0 : alhr_r[sel_r] + 8'd1;
          if (!al)                            ui_r <= SHOW_TIME;
          else if (!set_al_hr && !set_al_min) ui_r <= ALARM_SET;
          else if (!set_al_hr)                ui_r <= EDIT_MIN;
        end
        EDIT_MIN: begin
          if (inc) almin_r[sel_r] <= (almin_r[sel_r] >= MIN_MAX) ? 8'd0 : almin_r[sel_r] + 8'd1;
          if (!al)                            ui_r <= SHOW_TIME;
          else if (!set_al_hr && !set_al_min) ui_r <= ALARM_SET;
          else if (!set_al_min)               ui_r <= EDIT_HR;
        end
        ALARM_SET: begin
          alen_r[sel_r] <= 1'b1;
          ui_r          <= SHOW_ALARM;
        end
        default: ui_r <= SHOW_TIME;
      endcase
    end
  end

  // Ring FSM: trigger on minute edge, snooze/stop handling, auto-off
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_r     <= R_IDLE;
      buzzer_r   <= 1'b0;
      snoozed_r  <= 1'b0;
      ring_id_r  <= '0;
      snz_cnt_r  <= 8'd0;
      ring_cnt_r <= 8'd0;
      wake_r     <= '0;
    end else begin
      case (ring_r)
        R_IDLE: begin
          if (tick_s && hit_s) begin
            ring_id_r  <= hit_idx_s;
            snz_cnt_r  <= 8'd0;
            ring_cnt_r <= 8'd0;
            ring_r     <= R_RING;
            buzzer_r   <= 1'b1;
          end
        end
        R_RING: begin
          // An exhausted snooze budget turns snooze into stop
          if (stop || (snooze && (snz_cnt_r >= 8'(MAX_SNOOZE)))) begin
            ring_r   <= R_IDLE;
            buzzer_r <= 1'b0;
          end else if (snooze) begin
            wake_r    <= snooze_wake_s;
            snz_cnt_r <= snz_cnt_r + 8'd1;
            ring_r    <= R_SNOOZE;
            buzzer_r  <= 1'b0;
            snoozed_r <= 1'b1;
          end else if (tick_s) begin
            if (ring_cnt_r >= 8'(RING_MIN - 1)) begin
              ring_r   <= R_IDLE;
              buzzer_r <= 1'b0;
            end else begin
              ring_cnt_r <= ring_cnt_r + 8'd1;
            end
          end
        end
        R_SNOOZE: begin
          if (stop) begin
            ring_r    <= R_IDLE;
            snoozed_r <= 1'b0;
          end else if (tick_s && (hr == wake_r.hr) && (min == wake_r.min)) begin
            ring_cnt_r <= 8'd0;
            ring_r     <= R_RING;
            buzzer_r   <= 1'b1;
            snoozed_r  <= 1'b0;
          end
        end
        default: begin
          ring_r    <= R_IDLE;
          buzzer_r  <= 1'b0;
          snoozed_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Directed self-checking bench for alarm_ctrl_multi (default parameters).
module tb_alarm_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] hr, min;
  logic       al, sel_next, set_al_hr, set_al_min, inc, en_toggle, snooze, stop;
  logic [1:0] al_sel;
  logic [7:0] al_hr, al_min;
  logic       al_en;
  logic [2:0] ui_state;
  logic       buzzer;
  logic [1:0] ring_id;
  logic       snoozed;

  int errors = 0;
  int checks = 0;
  int mh[4];
  int mm[4];
  int cur_sel;
  int hits;

  alarm_ctrl_multi dut (
    .clk(clk), .rst(rst), .hr(hr), .min(min), .al(al), .sel_next(sel_next),
    .set_al_hr(set_al_hr), .set_al_min(set_al_min), .inc(inc), .en_toggle(en_toggle),
    .snooze(snooze), .stop(stop), .al_sel(al_sel), .al_hr(al_hr), .al_min(al_min),
    .al_en(al_en), .ui_state(ui_state), .buzzer(buzzer), .ring_id(ring_id), .snoozed(snoozed)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m);
    hr  = 8'(h);
    min = 8'(m);
    cyc();
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; cyc(); snooze = 1'b0;
  endtask

  // Assumes SHOW_ALARM; steps the selection with sel_next
  task automatic sel_to(input int idx);
    repeat ((idx - cur_sel + 4) % 4) begin
      sel_next = 1'b1; cyc(); sel_next = 1'b0;
    end
    cur_sel = idx;
  endtask

  task automatic edit_alarm(input int idx, input int dh, input int dm);
    al = 1'b1; cyc();
    sel_to(idx);
    if (dh > 0) begin
      set_al_hr = 1'b1; cyc();
      inc = 1'b1; repeat (dh) cyc(); inc = 1'b0;
      set_al_hr = 1'b0; cyc(); cyc();
    end
    if (dm > 0) begin
      set_al_min = 1'b1; cyc();
      inc = 1'b1; repeat (dm) cyc(); inc = 1'b0;
      set_al_min = 1'b0; cyc(); cyc();
    end
    mh[idx] = (mh[idx] + dh) % 24;
    mm[idx] = (mm[idx] + dm) % 60;
    chk($sformatf("edit%0d_hr", idx), al_hr, mh[idx]);
    chk($sformatf("edit%0d_min", idx), al_min, mm[idx]);
    chk($sformatf("edit%0d_en", idx), al_en, 1);
    al = 1'b0; cyc();
  endtask

  initial begin
    rst = 1'b1; hr = 8'd0; min = 8'd0; al = 1'b0; sel_next = 1'b0; set_al_hr = 1'b0;
    set_al_min = 1'b0; inc = 1'b0; en_toggle = 1'b0; snooze = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin mh[i] = 0; mm[i] = 0; end
    cur_sel = 0;
    cyc(); cyc();
    chk("rst_ui", ui_state, 0);
    chk("rst_sel", al_sel, 0);
    chk("rst_hr", al_hr, 0);
    chk("rst_en", al_en, 0);
    chk("rst_buzz", buzzer, 0);
    chk("rst_snz", snoozed, 0);
    chk("rst_rid", ring_id, 0);
    rst = 1'b0;

    // 25 hour increments wrap to 01, ALARM_SET enables
    al = 1'b1; cyc();
    chk("ui_show_alarm", ui_state, 3'b001);
    set_al_hr = 1'b1; cyc();
    chk("ui_edit_hr", ui_state, 3'b010);
    inc = 1'b1; repeat (25) cyc(); inc = 1'b0;
    chk("hr_wrap", al_hr, 1);
    set_al_hr = 1'b0; cyc();
    chk("ui_alarm_set", ui_state, 3'b011);
    chk("en_before_set", al_en, 0);
    cyc();
    chk("ui_back_show", ui_state, 3'b001);
    chk("en_after_set", al_en, 1);
    al = 1'b0; cyc();
    chk("ui_show_time", ui_state, 3'b000);
    chk("a0_min", al_min, 0);
    mh[0] = 1;

    // Alarm0 07:30 fires once per minute, no retrigger after stop
    edit_alarm(0, 6, 30);
    set_time(7, 29);
    chk("pre_fire", buzzer, 0);
    set_time(7, 30);
    chk("fire_buzz", buzzer, 1);
    chk("fire_rid", ring_id, 0);
    pulse_stop();
    chk("stop_buzz", buzzer, 0);
    hits = 0;
    repeat (1000) begin cyc(); if (buzzer) hits++; end
    chk("no_retrigger", hits, 0);

    // Alarms 1 and 2 at 06:00 (alarm2 via 60 minute increments), lowest index wins
    edit_alarm(1, 6, 0);
    edit_alarm(2, 6, 60);
    edit_alarm(3, 23, 57);
    set_time(5, 59);
    set_time(6, 0);
    chk("dual_buzz", buzzer, 1);
    chk("dual_rid", ring_id, 1);
    pulse_stop();
    chk("dual_stop", buzzer, 0);
    chk("dual_snz", snoozed, 0);

    // Disable alarm1 (selection wraps 3 -> 0 -> 1), alarm2 now rings
    al = 1'b1; cyc();
    sel_to(1);
    chk("sel_wrap", al_sel, 1);
    en_toggle = 1'b1; cyc(); en_toggle = 1'b0;
    chk("toggle_en", al_en, 0);
    al = 1'b0; cyc();
    set_time(5, 59);
    set_time(6, 0);
    chk("dis_rid", ring_id, 2);
    chk("dis_buzz", buzzer, 1);
    pulse_stop();

    // Snooze across midnight and snooze limit
    set_time(23, 56);
    set_time(23, 57);
    chk("late_buzz", buzzer, 1);
    chk("late_rid", ring_id, 3);
    pulse_snooze();
    chk("snz1_snz", snoozed, 1);
    chk("snz1_buzz", buzzer, 0);
    set_time(23, 58); set_time(23, 59); set_time(0, 0); set_time(0, 1);
    chk("snz1_wait", snoozed, 1);
    set_time(0, 2);
    chk("wake1_buzz", buzzer, 1);
    chk("wake1_snz", snoozed, 0);
    pulse_snooze();
    set_time(0, 5);
    chk("snz2_wait", snoozed, 1);
    set_time(0, 7);
    chk("wake2_buzz", buzzer, 1);
    pulse_snooze();
    set_time(0, 12);
    chk("wake3_buzz", buzzer, 1);
    pulse_snooze();
    chk("snz4_buzz", buzzer, 0);
    chk("snz4_snz", snoozed, 0);
    set_time(0, 17);
    chk("snz4_idle", buzzer, 0);

    // Auto-off after RING_MIN ticks
    set_time(7, 29);
    set_time(7, 30);
    chk("auto_start", buzzer, 1);
    set_time(7, 31);
    chk("auto_t1", buzzer, 1);
    set_time(7, 32);
    chk("auto_t2", buzzer, 1);
    set_time(7, 33);
    chk("auto_t3", buzzer, 0);

    // snooze and stop together: stop wins
    set_time(5, 59);
    set_time(6, 0);
    chk("ss_start", buzzer, 1);
    snooze = 1'b1; stop = 1'b1; cyc(); snooze = 1'b0; stop = 1'b0;
    chk("ss_buzz", buzzer, 0);
    chk("ss_snz", snoozed, 0);
    set_time(6, 5);
    chk("ss_no_wake", buzzer, 0);

    // Reset in the middle of a ring
    set_time(7, 29);
    set_time(7, 30);
    chk("rr_start", buzzer, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rr_buzz", buzzer, 0);
    chk("rr_ui", ui_state, 0);
    chk("rr_sel", al_sel, 0);
    chk("rr_hr", al_hr, 0);
    chk("rr_min", al_min, 0);
    chk("rr_en", al_en, 0);
    cur_sel = 0;
    al = 1'b1; cyc();
    sel_to(3);
    chk("rr_a3_hr", al_hr, 0);
    chk("rr_a3_min", al_min, 0);
    chk("rr_a3_en", al_en, 0);
    al = 1'b0; cyc();
    set_time(23, 56);
    set_time(23, 57);
    chk("rr_no_ring", buzzer, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl_multi.md
Name: alarm_ctrl_multi

Overview:
Parametrised multi-alarm controller; successor to the single-alarm FSM.
- Holds N_ALARMS programmable alarms with per-alarm enable.
- Edits alarms through a pulse-driven UI FSM: one increment per press, hours wrap at 24, minutes wrap at 60.
- Runs a separate ring FSM with snooze, snooze limit and auto-off timeout.
- Sits beside the timekeeping counter, which supplies hr/min in binary. Drives the buzzer and the display mux.

Parameters:
N_ALARMS, 4, number of alarm channels (1..16)
IDX_W, $clog2(N_ALARMS) min 1, alarm index width
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_MIN, 3, minutes of ringing before auto-off (1..59)
MAX_SNOOZE, 3, snoozes allowed per ring event; further snooze acts as stop

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
hr  in  8  current hour, binary 0..23
min  in  8  current minute, binary 0..59
al  in  1  level; 1 = alarm view/edit mode
sel_next  in  1  pulse; select next alarm, index wraps N_ALARMS-1 -> 0
set_al_hr  in  1  level; hour-edit request
set_al_min  in  1  level; minute-edit request
inc  in  1  pulse; increment the field being edited
en_toggle  in  1  pulse; toggle enable of the selected alarm
snooze  in  1  pulse; snooze the ringing alarm
stop  in  1  pulse; silence the alarm and end the ring event
al_sel  out  IDX_W  selected alarm index
al_hr  out  8  hour of the selected alarm
al_min  out  8  minute of the selected alarm
al_en  out  1  enable of the selected alarm
ui_state  out  3  UI FSM state code
buzzer  out  1  1 while ring FSM is in RING
ring_id  out  IDX_W  index of the alarm that caused the current ring event
snoozed  out  1  1 while ring FSM is in SNOOZE

Behaviour:
Reset (sync, rst=1 at posedge):
- All alarms 00:00, disabled; al_sel=0.
- UI state SHOW_TIME; ring state IDLE; buzzer=0, snoozed=0, ring_id=0, snooze count=0, min_q=min.

Common rules:
- All outputs registered, except al_hr/al_min/al_en, which are combinational reads of the alarm array at al_sel.
- Pulse inputs are single-cycle, one action each. A pulse held high for k cycles acts k times; debouncing is upstream.

UI FSM states: SHOW_TIME=000, SHOW_ALARM=001, EDIT_HR=010, EDIT_MIN=100, ALARM_SET=011.
- SHOW_TIME: al=1 -> SHOW_ALARM.
- SHOW_ALARM:
  - al=0 -> SHOW_TIME.
  - else set_al_hr=1 -> EDIT_HR (hour has priority).
  - else set_al_min=1 -> EDIT_MIN.
  - sel_next and en_toggle act only in this state.
- EDIT_HR:
  - Each inc pulse: hr_field = (hr_field==23) ? 0 : hr_field+1.
  - Both set lines 0 -> ALARM_SET. set_al_min=1 with set_al_hr=0 -> EDIT_MIN. Otherwise stay.
- EDIT_MIN: same as EDIT_HR; minute wraps 59 -> 0. set_al_hr=1 with set_al_min=0 -> EDIT_HR.
- ALARM_SET (1 cycle): set enable of al_sel to 1 -> SHOW_ALARM.
- al=0 in any EDIT state -> SHOW_TIME; edits made so far are kept, enable is unchanged.
- Editing never causes a carry from minutes into hours.

Minute edge:
- tick = (min != min_q); min_q <= min every cycle.
- Matching and timeouts are evaluated only on tick. An alarm therefore fires once per minute, not on every cycle of a matching minute.

Ring FSM states: IDLE, RING, SNOOZE.
- IDLE: on tick, if any enabled alarm has hr/min equal to inputs:
  - ring_id <= lowest matching index; snooze count <= 0; ring minute counter <= 0; -> RING.
- RING:
  - stop -> IDLE.
  - snooze with count < MAX_SNOOZE:
    - wake = (hr,min) + SNOOZE_MIN, with minute wrap carrying into hour and 23:59 -> 00:xx;
    - count++; -> SNOOZE.
  - snooze with count == MAX_SNOOZE: acts as stop.
  - On tick, ring counter++; when it reaches RING_MIN -> IDLE (auto-off).
  - Other alarms matching during RING are ignored.
- SNOOZE:
  - stop -> IDLE.
  - tick with (hr,min) == wake -> RING; ring counter <= 0.
  - New matches of other alarms are ignored.
- stop and snooze in the same cycle: stop wins.
- Disabling or editing ring_id's alarm during RING/SNOOZE does not end the ring event.
- rst mid-ring: immediately IDLE, buzzer=0 on the next cycle.

Decomposition:
- Package alarm_pkg:
  - UI and ring state encodings;
  - HR_MAX=23, MIN_MAX=59;
  - a time-add function (hr, min, delta) -> wrapped (hr, min).
- One natural sub-module: alarm_match, combinational. It compares N_ALARMS entries with the current time and enables, and outputs hit plus the lowest index.

Test Plan:
- Reset, al=1, set_al_hr=1, 25 inc pulses, release, al=0 -> alarm0 = 01:00, al_en=1, ui_state sequence 001->010->011->001->000.
- Alarm0 07:30 enabled; min steps 29->30 with hr=7 -> buzzer=1 one cycle after tick, ring_id=0; hold 07:30 for 1000 cycles -> no retrigger after stop.
- Alarms 1 and 2 both 06:00 enabled -> ring_id=1; stop -> buzzer=0 next cycle, IDLE.
- Ringing at 23:57, snooze -> snoozed=1, wake 00:02; ring resumes at 00:02. The 4th snooze with MAX_SNOOZE=3 -> IDLE.
- Ring with no input for RING_MIN=3 minute ticks -> buzzer drops on the 3rd tick; snooze+stop in the same cycle -> IDLE, not SNOOZE.
- rst asserted while buzzer=1 -> buzzer=0, all alarms 00:00 disabled, ui_state=000.
